keypad_operand_scanner: RTL and testbench

- Input-side counterpart of the ALU's multiplexed seven-segment output.
- Scans a 4x4 matrix keypad by driving one column low at a time (active-low, time-multiplexed like the display anodes) and reading the rows.
- Debounces each key and assembles the 3-bit ALU operands A and B from successive digit presses.
- Flags each completed operand pair with a one-cycle strobe.

---
 rtl/keypad_operand_scanner.sv | 195 +++++++++++++++++++
 tb/tb_keypad_operand_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_scanner.sv
// 4x4 keypad scanner: column-multiplexed scan, per-key debounce and assembly
// of the 3-bit ALU operands A/B from successive digit presses.
module keypad_operand_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_err,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       op_valid,
  output logic [1:0] entry_state
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_N      = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0]     KEY_CLR   = 4'hC;

  typedef enum logic [1:0] {WAIT_A = 2'd0, WAIT_B = 2'd1, HOLD = 2'd2} state_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) low_idx = 2'(i);
  endfunction

  function automatic logic is_operand_key(input logic [3:0] k);
    is_operand_key = (k < 4'd8) || (k == KEY_CLR);
  endfunction

  logic [3:0]    r_row_s1, r_row_s2;
  logic [CW-1:0] r_slot_cnt;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_hits;
  logic [3:0]    r_acc_key;
  logic          r_pressed;
  logic [3:0]    r_db_cnt;
  logic [3:0]    r_db_key;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_err;
  state_t        r_state;
  logic [2:0]    r_a, r_b;
  logic          r_op_valid;

  logic [3:0] w_low;
  logic [2:0] w_slot_hits, w_sum;
  logic [1:0] w_base_hits, w_hits;
  logic [3:0] w_key;
  logic       w_slot_end, w_scan_end;
  logic [3:0] w_press_cnt;
  state_t     w_state_nxt;
  logic [2:0] w_a_nxt, w_b_nxt;
  logic       w_op_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  // Hits accumulate across the four slots; 2 means "two or more" (MULTI).
  assign w_low       = ~r_row_s2;
  assign w_slot_hits = popcnt4(w_low);
  assign w_base_hits = (r_col_idx == 2'd0) ? 2'd0 : r_hits;
  assign w_sum       = {1'b0, w_base_hits} + w_slot_hits;
  assign w_hits      = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_key       = (w_slot_hits == 3'd1) ? {low_idx(w_low), r_col_idx} :
                       (r_col_idx == 2'd0)   ? 4'd0 : r_acc_key;
  assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
  assign w_scan_end  = w_slot_end && (r_col_idx == 2'd3);
  assign w_press_cnt = (r_db_cnt != 4'd0 && w_key == r_db_key) ? r_db_cnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_cnt <= '0;
      r_col_idx  <= 2'd0;
      r_hits     <= 2'd0;
      r_acc_key  <= 4'd0;
    end else begin
      r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_end) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_hits    <= w_hits;
        r_acc_key <= w_key;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed   <= 1'b0;
      r_db_cnt    <= 4'd0;
      r_db_key    <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      if (w_scan_end) begin
        if (!r_pressed) begin
          if (w_hits == 2'd1) begin
            r_db_key <= w_key;
            if (w_press_cnt == DB_N) begin
              r_key_code  <= w_key;
              r_key_valid <= 1'b1;
              r_key_err   <= !is_operand_key(w_key);
              r_pressed   <= 1'b1;
              r_db_cnt    <= 4'd0;
            end else begin
              r_db_cnt <= w_press_cnt;
            end
          end else begin
            r_db_cnt <= 4'd0;
          end
        end else if (w_hits == 2'd0) begin
          if (r_db_cnt + 4'd1 == DB_N) begin
            r_pressed <= 1'b0;
            r_db_cnt  <= 4'd0;
          end else begin
            r_db_cnt <= r_db_cnt + 4'd1;
          end
        end else begin
          r_db_cnt <= 4'd0;
        end
      end
    end
  end

  // Operand entry: acts on the cycle key_valid is high.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = 1'b0;
    if (r_key_valid && !r_key_err) begin
      if (r_key_code == KEY_CLR) begin
        w_a_nxt     = 3'd0;
        w_b_nxt     = 3'd0;
        w_state_nxt = WAIT_A;
      end else begin
        case (r_state)
          WAIT_B: begin
            w_b_nxt     = r_key_code[2:0];
            w_op_nxt    = 1'b1;
            w_state_nxt = HOLD;
          end
          WAIT_A, HOLD: begin
            w_a_nxt     = r_key_code[2:0];
            w_state_nxt = WAIT_B;
          end
          default: w_state_nxt = WAIT_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= WAIT_A;
      r_a        <= 3'd0;
      r_b        <= 3'd0;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_op_valid <= w_op_nxt;
    end
  end

  assign col         = ~(4'b0001 << r_col_idx);
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_err     = r_key_err;
  assign A           = r_a;
  assign B           = r_b;
  assign op_valid    = r_op_valid;
  assign entry_state = r_state;

endmodule

// File: tb/tb_keypad_operand_scanner.sv
// Scoreboard bench for keypad_operand_scanner: a keypad model drives rows from
// the column strobe, expected key/operand events are queued and checked by a monitor.
module tb_keypad_operand_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_err, op_valid;
  logic [2:0] A, B;
  logic [1:0] entry_state;
  logic [15:0] keys = 16'h0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] code;
    logic       err;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] st;
  } kev_t;

  kev_t       key_q[$];
  logic [5:0] op_q[$];
  kev_t       cur;
  logic       pend = 1'b0;
  logic [5:0] opx;

  keypad_operand_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_err(key_err), .A(A), .B(B),
    .op_valid(op_valid), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  // Passive keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_key(input logic [3:0] code, input logic err,
                          input logic [2:0] a, input logic [2:0] b, input logic [1:0] st);
    kev_t e;
    e.code = code; e.err = err; e.a = a; e.b = b; e.st = st;
    key_q.push_back(e);
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("A after key", int'(A), int'(cur.a));
        chk("B after key", int'(B), int'(cur.b));
        chk("entry_state after key", int'(entry_state), int'(cur.st));
        pend = 1'b0;
      end
      if (op_valid) begin
        if (op_q.size() == 0) chk("op_valid with no pair expected", 0, 1);
        else begin
          opx = op_q.pop_front();
          chk("op_valid A", int'(A), int'(opx[5:3]));
          chk("op_valid B", int'(B), int'(opx[2:0]));
        end
      end
      if (key_err && !key_valid) chk("key_err without key_valid", int'(key_valid), 1);
      if (key_valid) begin
        if (key_q.size() == 0) chk("key_valid with no key expected", 0, 1);
        else begin
          cur = key_q.pop_front();
          chk("key_code", int'(key_code), int'(cur.code));
          chk("key_err", int'(key_err), int'(cur.err));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset col", int'(col), 4'b1110);
    chk("reset A", int'(A), 0);
    chk("reset B", int'(B), 0);
    chk("reset key_code", int'(key_code), 0);
    chk("reset key_valid", int'(key_valid), 0);
    chk("reset op_valid", int'(op_valid), 0);
    chk("reset entry_state", int'(entry_state), 0);
    rst_n = 1'b1;
    for (int k = 0; k < SCAN; k++) begin
      chk($sformatf("col at cycle %0d", k), int'(col), int'(~(4'b0001 << ((k / SD) % 4)) & 4'hF));
      @(negedge clk);
    end

    // Key 5 held 6 scans: one acceptance, A=5, WAIT_B.
    push_key(4'd5, 1'b0, 3'd5, 3'd0, 2'd1);
    keys[5] = 1'b1;
    scans(6);
    chk("key 5 consumed", key_q.size(), 0);
    keys = 16'h0;
    scans(4);

    // Key 3 completes the pair.
    push_key(4'd3, 1'b0, 3'd5, 3'd3, 2'd2);
    op_q.push_back({3'd5, 3'd3});
    keys[3] = 1'b1;
    scans(5);
    chk("key 3 consumed", key_q.size(), 0);
    chk("op pair consumed", op_q.size(), 0);
    keys = 16'h0;
    scans(4);

    // Key 6 bouncing every scan never debounces.
    repeat (5) begin
      keys[6] = 1'b1; scans(1);
      keys[6] = 1'b0; scans(1);
    end
    chk("bounce A", int'(A), 5);
    chk("bounce B", int'(B), 3);
    chk("bounce entry_state", int'(entry_state), 2);

    // Keys 1+2 together are MULTI; releasing 2 lets 1 through.
    keys[1] = 1'b1; keys[2] = 1'b1;
    scans(5);
    chk("multi no key", int'(key_code), 3);
    push_key(4'd1, 1'b0, 3'd1, 3'd3, 2'd1);
    keys[2] = 1'b0;
    scans(4);
    keys = 16'h0;
    scans(4);

    // Key 9 is an error; clear key zeroes the operands.
    push_key(4'd9, 1'b1, 3'd1, 3'd3, 2'd1);
    keys[9] = 1'b1; scans(4);
    keys = 16'h0;   scans(4);
    push_key(4'hC, 1'b0, 3'd0, 3'd0, 2'd0);
    keys[12] = 1'b1; scans(4);
    keys = 16'h0;    scans(4);

    // Reset in the middle of the 2nd debounce scan of key 7, key kept held.
    keys[7] = 1'b1;
    scans(1);
    repeat (SD * 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset col", int'(col), 4'b1110);
    chk("mid reset key_code", int'(key_code), 0);
    chk("mid reset A", int'(A), 0);
    chk("mid reset entry_state", int'(entry_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_key(4'd7, 1'b0, 3'd7, 3'd0, 2'd1);
    repeat (DB * SCAN - 1) @(negedge clk);
    chk("key 7 not accepted before 3 scans", key_q.size(), 1);
    scans(2);
    chk("key 7 consumed", key_q.size(), 0);
    keys = 16'h0;
    scans(4);

    chk("key queue drained", key_q.size(), 0);
    chk("op queue drained", op_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
